ula_ctrl: RTL and testbench

Sequencing front end for the `ula` ALU: accepts one instruction at a time over a valid/ready handshake and decodes it. It reads operands from an internal 8×8-bit register file, drives the ALU's `A`/`B`/`opcode` inputs, captures the ALU result and writes it back, then reports completion. It sits between the instruction source (switches/testbench/fetch logic) and the combinational ALU, and is the producer side of the ALU's operand/opcode interface.

---
 rtl/ula_pkg.sv | 43 ++++
 rtl/banco_regs.sv | 32 +++
 rtl/ula.sv | 23 ++
 rtl/ula_ctrl.sv | 135 +++++++++++++
 tb/tb_ula_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared opcode, FSM-state and instruction-field definitions for ula and ula_ctrl.
package ula_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_DONE
    } state_t;

    // Instruction word: {op, rd, rs, imm}
    localparam int INSTR_W = 17;
    localparam int OP_MSB  = 16;
    localparam int OP_LSB  = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

    function automatic logic is_imm_op(input logic [2:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic writes_reg(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_ILL);
    endfunction

endpackage

// File: rtl/banco_regs.sv
// Register file: one synchronous write port, two combinational read ports, R0 reads as zero.
module banco_regs #(
    parameter int NREGS = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    output logic [W-1:0]             rdata_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [W-1:0]             rdata_b
);

    logic [W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/ula.sv
// Combinational ALU: add, subtract and low half of the product, all modulo 2^W.
module ula
    import ula_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   opcode,
    output logic [W-1:0] res
);

    always_comb begin
        res = '0;
        case (opcode)
            OP_ADD, OP_ADDI: res = a + b;
            OP_SUB, OP_SUBI: res = a - b;
            OP_MUL:          res = a * b;
            default:         res = '0;
        endcase
    end

endmodule

// File: rtl/ula_ctrl.sv
// Sequencer in front of the ula ALU: IDLE -> READ -> EXEC -> DONE, one instruction per 4 cycles.
// Optional overflow flag is built only when ULA_CTRL_OVF_EN is defined.
module ula_ctrl
    import ula_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [W-1:0]       alu_res,
    output logic               done,
    output logic [W-1:0]       result,
    output logic               err,
    output logic               ovf
);

    state_t             state;
    logic [INSTR_W-1:0] instr_q;
    logic [2:0]         op;
    logic [2:0]         rd;
    logic [2:0]         rs;
    logic [7:0]         imm;
    logic [W-1:0]       rdata_a;
    logic [W-1:0]       rdata_b;
    logic               we;
    logic [W-1:0]       wdata;

    assign op  = instr_q[OP_MSB:OP_LSB];
    assign rd  = instr_q[RD_MSB:RD_LSB];
    assign rs  = instr_q[RS_MSB:RS_LSB];
    assign imm = instr_q[IMM_MSB:IMM_LSB];

    // Write lands at the EXEC->DONE edge, so the next READ already sees it.
    assign we    = (state == ST_EXEC) && writes_reg(op);
    assign wdata = (op == OP_LOAD) ? W'(imm) : alu_res;

    banco_regs #(
        .NREGS (NREGS),
        .W     (W)
    ) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (rd),
        .wdata   (wdata),
        .raddr_a (rs),
        .rdata_a (rdata_a),
        .raddr_b (imm[2:0]),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= OP_NOP;
            done        <= 1'b0;
            err         <= 1'b0;
            result      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_a      <= rdata_a;
                    alu_b      <= is_imm_op(op) ? W'(imm) : rdata_b;
                    alu_opcode <= is_alu_op(op) ? op : OP_NOP;
                    state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op == OP_LOAD) begin
                        result <= W'(imm);
                    end else if (is_alu_op(op)) begin
                        result <= alu_res;
                    end else begin
                        result <= '0;
                    end
                    done  <= 1'b1;
                    err   <= (op == OP_ILL);
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ULA_CTRL_OVF_EN
    logic [2*W-1:0] prod;
    logic           ovf_next;

    assign prod = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};

    always_comb begin
        ovf_next = 1'b0;
        case (alu_opcode)
            OP_ADD, OP_ADDI: ovf_next = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            OP_SUB, OP_SUBI: ovf_next = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            OP_MUL:          ovf_next = (prod[2*W-1:W] != '0);
            default:         ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (state == ST_EXEC) ? ovf_next : 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed bench for ula_ctrl driving the ula ALU, with an expected-result scoreboard.
module tb_ula_ctrl;
    import ula_pkg::*;

`ifdef ULA_CTRL_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [7:0]         alu_a;
    logic [7:0]         alu_b;
    logic [2:0]         alu_opcode;
    logic [7:0]         alu_res;
    logic               done;
    logic [7:0]         result;
    logic               err;
    logic               ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done = 0;

    logic [9:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ula_ctrl #(.NREGS(8), .W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_res     (alu_res),
        .done        (done),
        .result      (result),
        .err         (err),
        .ovf         (ovf)
    );

    ula #(.W(8)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .opcode (alu_opcode),
        .res    (alu_res)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [7:0] imm, input logic [7:0] e_res, input logic e_err,
                        input logic e_ovf, input bit chk_alu = 1'b0,
                        input logic [7:0] e_a = 8'h0, input logic [7:0] e_b = 8'h0);
        int n;
        int xfer;
        logic [9:0] e;
        sb.push_back({e_res, e_err, OVF_ON & e_ovf});
        instr       = {op, rd, rs, imm};
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {15'h0, instr_ready}, 16'h1);
        tick();
        instr_valid = 1'b0;
        xfer = cyc;
        tick();
        if (chk_alu) begin
            chk("alu_a", {8'h0, alu_a}, {8'h0, e_a});
            chk("alu_b", {8'h0, alu_b}, {8'h0, e_b});
            chk("alu_opcode", {13'h0, alu_opcode}, {13'h0, op});
        end
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("done_seen", {15'h0, done}, 16'h1);
        chk("latency", 16'(cyc - xfer), 16'd2);
        e = sb.pop_front();
        chk("result", {8'h0, result}, {8'h0, e[9:2]});
        chk("err", {15'h0, err}, {15'h0, e[1]});
        chk("ovf", {15'h0, ovf}, {15'h0, e[0]});
        last_done = cyc;
        tick();
        chk("done_drop", {15'h0, done}, 16'h0);
        chk("ready_back", {15'h0, instr_ready}, 16'h1);
        chk("result_hold", {8'h0, result}, {8'h0, e[9:2]});
    endtask

    initial begin
        int d1;
        int pulses;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (3) tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_ready", {15'h0, instr_ready}, 16'h1);
        chk("rst_done", {15'h0, done}, 16'h0);
        chk("rst_err", {15'h0, err}, 16'h0);
        chk("rst_ovf", {15'h0, ovf}, 16'h0);
        chk("rst_result", {8'h0, result}, 16'h0);
        chk("rst_alu_a", {8'h0, alu_a}, 16'h0);
        chk("rst_alu_b", {8'h0, alu_b}, 16'h0);
        chk("rst_alu_opcode", {13'h0, alu_opcode}, 16'h0);

        // Wrap-around add; operands of opposite sign cannot overflow signed
        send(OP_LOAD, 3'd1, 3'd0, 8'd200, 8'd200, 1'b0, 1'b0);
        send(OP_LOAD, 3'd2, 3'd0, 8'd100, 8'd100, 1'b0, 1'b0);
        send(OP_ADD,  3'd3, 3'd1, 8'd2,   8'd44,  1'b0, 1'b0, 1'b1, 8'd200, 8'd100);

        send(OP_ADDI, 3'd4, 3'd0, 8'd5,  8'd5,   1'b0, 1'b0);
        d1 = last_done;
        send(OP_SUBI, 3'd5, 3'd4, 8'd10, 8'd251, 1'b0, 1'b0, 1'b1, 8'd5, 8'd10);
        chk("done_spacing", 16'(last_done - d1), 16'd4);
        send(OP_ADDI, 3'd7, 3'd5, 8'd0,  8'd251, 1'b0, 1'b0);

        // 20*13 = 260, low byte 4, unsigned product overflow
        send(OP_LOAD, 3'd1, 3'd0, 8'd20, 8'd20, 1'b0, 1'b0);
        send(OP_LOAD, 3'd2, 3'd0, 8'd13, 8'd13, 1'b0, 1'b0);
        send(OP_MUL,  3'd6, 3'd1, 8'd2,  8'd4,  1'b0, 1'b1, 1'b1, 8'd20, 8'd13);

        // Illegal and NOP leave R3 = 44
        send(OP_ILL,  3'd3, 3'd1, 8'd2, 8'd0,  1'b1, 1'b0);
        send(OP_ADDI, 3'd3, 3'd3, 8'd0, 8'd44, 1'b0, 1'b0);
        send(OP_NOP,  3'd3, 3'd1, 8'd2, 8'd0,  1'b0, 1'b0);
        send(OP_ADDI, 3'd3, 3'd3, 8'd0, 8'd44, 1'b0, 1'b0);

        // R0 write discarded
        send(OP_LOAD, 3'd0, 3'd0, 8'd77, 8'd77, 1'b0, 1'b0);
        send(OP_ADDI, 3'd1, 3'd0, 8'd0,  8'd0,  1'b0, 1'b0);

        // Abort during EXEC
        instr       = {OP_ADDI, 3'd2, 3'd0, 8'd9};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {15'h0, instr_ready}, 16'h1);
        chk("abort_done", {15'h0, done}, 16'h0);
        tick();
        tick();
        chk("abort_done_late", {15'h0, done}, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        send(OP_ADDI, 3'd7, 3'd2, 8'd0, 8'd0, 1'b0, 1'b0);

        // Valid held through READ/EXEC/DONE: exactly one acceptance
        instr       = {OP_ADDI, 3'd4, 3'd0, 8'd3};
        instr_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                instr_valid = 1'b0;
                chk("held_result", {8'h0, result}, 16'd3);
            end
        end
        instr_valid = 1'b0;
        chk("held_pulses", 16'(pulses), 16'd1);
        send(OP_ADDI, 3'd5, 3'd4, 8'd1, 8'd4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
